// File: rtl/s_cpu_sequencer.sv
// s_cpu_sequencer: SPC700 micro-state sequencer with branch conditions, RUN/WAIT/SLEEP/STOP modes, cycle count; optional watchdog via S_SEQ_WATCHDOG_EN
module s_cpu_sequencer #(
  parameter int STATE_W  = 7,
  parameter int OPFETCH  = 0,
  parameter int PSW_W    = 8,
  parameter int N_BIT    = 7,
  parameter int V_BIT    = 6,
  parameter int Z_BIT    = 1,
  parameter int C_BIT    = 0,
  parameter int CNT_W    = 4,
  parameter int WDOG_MAX = 15
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cpu_en_i,
  input  logic               bus_ready_i,
  input  logic [STATE_W-1:0] next_state_i,
  input  logic [3:0]         cond_sel_i,
  input  logic [PSW_W-1:0]   psw_i,
  input  logic [7:0]         bit_in_i,
  input  logic [2:0]         bit_sel_i,
  input  logic               cnt_zero_i,
  input  logic               sleep_req_i,
  input  logic               stop_req_i,
  input  logic               irq_i,
  output logic [STATE_W-1:0] state_o,
  output logic [1:0]         mode_o,
  output logic               cond_false_o,
  output logic               instr_done_o,
  output logic [CNT_W-1:0]   instr_cycles_o,
  output logic               wdog_hang_o
);
  typedef enum logic [1:0] {RUN, WAIT, SLEEP, STOP} mode_e;
  localparam logic [STATE_W-1:0] OPF = STATE_W'(OPFETCH);
  mode_e              mode_q, mode_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cyc_q, cyc_d, cnt_inc;
  logic               done_q, done_d, run, adv, fin, unused_ok;
  assign run     = (mode_q == RUN) || (mode_q == WAIT);
  assign adv     = cpu_en_i & bus_ready_i & run;
  assign fin     = adv && (next_state_i == OPF) && (state_q != OPF);
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign unused_ok = ^{psw_i, WDOG_MAX[0]};
`ifdef S_SEQ_WATCHDOG_EN
  logic hang_q, hang_d;
`endif
  // next micro-state, mode and cycle accounting
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    if (run && cpu_en_i) begin
      cnt_d   = cnt_inc;
      mode_d  = bus_ready_i ? RUN : WAIT;
      state_d = bus_ready_i ? next_state_i : state_q;
    end
    if (fin) begin
      done_d = 1'b1;
      cyc_d  = cnt_inc;
      cnt_d  = '0;
      mode_d = stop_req_i ? STOP : sleep_req_i ? SLEEP : RUN;
    end
    if (mode_q == SLEEP && irq_i && cpu_en_i) mode_d = RUN;
`ifdef S_SEQ_WATCHDOG_EN
    hang_d = hang_q;
    if (run && state_q != OPF && cnt_q == CNT_W'(WDOG_MAX)) begin
      state_d = OPF;
      mode_d  = RUN;
      cnt_d   = '0;
      cyc_d   = cyc_q;
      done_d  = 1'b0;
      hang_d  = 1'b1;
    end
`endif
  end
  // sequencer state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= OPF;
      mode_q  <= RUN;
      cnt_q   <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end
`ifdef S_SEQ_WATCHDOG_EN
  // sticky hang flag, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) hang_q <= 1'b0;
    else          hang_q <= hang_d;
  end
  assign wdog_hang_o = hang_q;
`else
  assign wdog_hang_o = 1'b0;
`endif
  // branch-not-taken decode
  always_comb begin
    cond_false_o = 1'b0;
    case (cond_sel_i)
      4'd1:        cond_false_o = ~psw_i[Z_BIT];
      4'd2:        cond_false_o =  psw_i[Z_BIT];
      4'd3:        cond_false_o = ~psw_i[C_BIT];
      4'd4:        cond_false_o =  psw_i[C_BIT];
      4'd5:        cond_false_o = ~psw_i[V_BIT];
      4'd6:        cond_false_o =  psw_i[V_BIT];
      4'd7:        cond_false_o = ~psw_i[N_BIT];
      4'd8:        cond_false_o =  psw_i[N_BIT];
      4'd9:        cond_false_o = ~bit_in_i[bit_sel_i];
      4'd10:       cond_false_o =  bit_in_i[bit_sel_i];
      4'd11, 4'd12: cond_false_o = cnt_zero_i;
      default:     cond_false_o = 1'b0;
    endcase
  end
  assign state_o        = state_q;
  assign mode_o         = mode_q;
  assign instr_done_o   = done_q;
  assign instr_cycles_o = cyc_q;
endmodule

// File: tb/tb_s_cpu_sequencer.sv
// tb_s_cpu_sequencer: directed and randomized checks of s_cpu_sequencer against a behavioural model
module tb_s_cpu_sequencer;
`ifdef S_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b1, cpu_en = 1'b0, bus_ready = 1'b1;
  logic [6:0] next_state = '0;
  logic [3:0] cond_sel = '0;
  logic [7:0] psw = '0, bit_in = '0;
  logic [2:0] bit_sel = '0;
  logic       cnt_zero = 1'b0, sleep_req = 1'b0, stop_req = 1'b0, irq = 1'b0;
  logic [6:0] state;
  logic [1:0] mode;
  logic       cond_false, instr_done, wdog_hang;
  logic [3:0] instr_cycles;
  int checks = 0, failures = 0;
  int m_state = 0, m_mode = 0, m_cnt = 0, m_cyc = 0;
  bit m_done = 0, m_hang = 0, saw_done;

  s_cpu_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n), .cpu_en_i(cpu_en), .bus_ready_i(bus_ready),
    .next_state_i(next_state), .cond_sel_i(cond_sel), .psw_i(psw), .bit_in_i(bit_in),
    .bit_sel_i(bit_sel), .cnt_zero_i(cnt_zero), .sleep_req_i(sleep_req), .stop_req_i(stop_req),
    .irq_i(irq), .state_o(state), .mode_o(mode), .cond_false_o(cond_false),
    .instr_done_o(instr_done), .instr_cycles_o(instr_cycles), .wdog_hang_o(wdog_hang)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_cf();
    case (cond_sel)
      1: return !psw[1];
      2: return psw[1];
      3: return !psw[0];
      4: return psw[0];
      5: return !psw[6];
      6: return psw[6];
      7: return !psw[7];
      8: return psw[7];
      9: return !bit_in[bit_sel];
      10: return bit_in[bit_sel];
      11, 12: return cnt_zero;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_state));
    chk({tag, ".mode"}, 32'(mode), 32'(m_mode));
    chk({tag, ".done"}, 32'(instr_done), 32'(m_done));
    chk({tag, ".cycles"}, 32'(instr_cycles), 32'(m_cyc));
    chk({tag, ".hang"}, 32'(wdog_hang), 32'(m_hang));
    chk({tag, ".cond"}, 32'(cond_false), 32'(exp_cf()));
  endtask

  // one clock: predict from the rules, advance, compare
  task automatic tick(input string tag);
    int n_state = m_state, n_mode = m_mode, n_cnt = m_cnt, n_cyc = m_cyc;
    bit n_done = 0, n_hang = m_hang;
    bit run = m_mode < 2;
    if (WD && run && m_state != 0 && m_cnt == 15) begin
      n_state = 0; n_mode = 0; n_cnt = 0; n_hang = 1;
    end else begin
      if (run && cpu_en) begin
        n_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        if (!bus_ready) n_mode = 1;
        else if (next_state == 0 && m_state != 0) begin
          n_done = 1; n_cyc = n_cnt; n_cnt = 0; n_state = 0;
          n_mode = stop_req ? 3 : sleep_req ? 2 : 0;
        end else begin
          n_state = int'(next_state); n_mode = 0;
        end
      end
      if (m_mode == 2 && irq && cpu_en) n_mode = 0;
    end
    @(posedge clk);
    #1;
    m_state = n_state; m_mode = n_mode; m_cnt = n_cnt; m_cyc = n_cyc; m_done = n_done; m_hang = n_hang;
    check_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_state = 0; m_mode = 0; m_cnt = 0; m_cyc = 0; m_done = 0; m_hang = 0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    check_all("reset_hold");
    rst_n = 1'b1;
  endtask

  task automatic set_in(input logic en, input logic rdy, input logic [6:0] ns,
                        input logic slp, input logic stp, input logic ir);
    cpu_en = en; bus_ready = rdy; next_state = ns; sleep_req = slp; stop_req = stp; irq = ir;
  endtask

  initial begin
    #2;
    // reset release into state 5
    set_in(1, 1, 7'd5, 0, 0, 0);
    do_reset();
    chk("rst_state0", 32'(state), 0);
    tick("first");
    chk("rst_state5", 32'(state), 5);
    // stall in state 3
    set_in(1, 1, 7'd0, 0, 0, 0); tick("fin5");
    set_in(1, 1, 7'd3, 0, 0, 0); tick("to3");
    bus_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick("stall");
      chk("stall_mode", 32'(mode), 1);
      chk("stall_state", 32'(state), 3);
    end
    set_in(1, 1, 7'd0, 0, 0, 0); tick("fin3");
    chk("stall_done", 32'(instr_done), 1);
    chk("stall_cycles", 32'(instr_cycles), 4);
    tick("after_fin3");
    chk("done_pulse", 32'(instr_done), 0);
    // branch conditions
    psw = 8'h02; cond_sel = 4'd1; #1 chk("beq", 32'(cond_false), 0);
    cond_sel = 4'd2; #1 chk("bne", 32'(cond_false), 1);
    bit_in = 8'h20; bit_sel = 3'd5; cond_sel = 4'd9; #1 chk("bbs", 32'(cond_false), 0);
    cond_sel = 4'd10; #1 chk("bbc", 32'(cond_false), 1);
    // reset mid-instruction
    set_in(1, 1, 7'd3, 0, 0, 0); tick("to3b");
    #2;
    do_reset();
    // sleep
    set_in(1, 1, 7'd3, 0, 0, 0); tick("s_to3");
    set_in(1, 1, 7'd0, 1, 0, 0); tick("s_fin");
    chk("sleep_mode", 32'(mode), 2);
    set_in(1, 1, 7'd4, 0, 0, 0); tick("s_frozen");
    chk("sleep_state", 32'(state), 0);
    set_in(0, 1, 7'd4, 0, 0, 1); tick("s_irq_noen");
    chk("sleep_hold", 32'(mode), 2);
    set_in(1, 1, 7'd4, 0, 0, 1); tick("s_wake");
    chk("wake_mode", 32'(mode), 0);
    // stop
    set_in(1, 1, 7'd3, 0, 0, 0); tick("p_to3");
    set_in(1, 1, 7'd0, 1, 1, 0); tick("p_fin");
    chk("stop_mode", 32'(mode), 3);
    set_in(1, 1, 7'd6, 0, 0, 1);
    for (int i = 0; i < 3; i++) tick("p_irq");
    chk("stop_hold", 32'(mode), 3);
    do_reset();
    // watchdog
    set_in(1, 1, 7'd7, 0, 0, 0);
    do_reset();
    saw_done = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("wdog");
      if (instr_done) saw_done = 1;
      if (i == 16) chk("wdog_force", 32'(state), WD ? 0 : 7);
    end
    chk("wdog_hang", 32'(wdog_hang), 32'(WD));
    chk("wdog_no_done", 32'(saw_done), 0);
    // randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
             ($urandom_range(0, 2) == 0) ? 7'd0 : 7'($urandom_range(1, 127)),
             $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) == 0);
      psw = 8'($urandom); bit_in = 8'($urandom); bit_sel = 3'($urandom);
      cond_sel = 4'($urandom); cnt_zero = 1'($urandom);
      if (m_mode == 3 && $urandom_range(0, 3) == 0) do_reset();
      else tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
